// File: rtl/mem_interface.sv
// Memory interface with MAR/MDR registers and a single-port 32-bit RAM.
// Reads take three edges from request to done; writes take two.
module mem_interface #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] BusMuxOut,
    input  logic        MAR_in,
    input  logic        MDR_in,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] MDR_out,
    output logic [31:0] MAR_out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD1  = 2'd1;
    localparam logic [1:0] RD2  = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [31:0]       mar_q, mdr_q, wdata_q, rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              start_rd, start_wr;
    logic [31:0]       ram [DEPTH];

    // Read wins when both requests arrive together; requests outside IDLE are dropped.
    assign start_rd = (state_q == IDLE) && Read;
    assign start_wr = (state_q == IDLE) && Write && !Read;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_rd) begin
                    state_d = RD1;
                end else if (start_wr) begin
                    state_d = WR;
                end
            end
            RD1:     state_d = RD2;
            RD2:     state_d = IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == RD2) || (state_q == WR);
            if (MAR_in) begin
                mar_q <= BusMuxOut;
            end
            // RAM data overrides a bus load in the final read cycle.
            if (state_q == RD2) begin
                mdr_q <= rdata_q;
            end else if (MDR_in) begin
                mdr_q <= BusMuxOut;
            end
            if (start_rd || start_wr) begin
                addr_q <= mar_q[ADDR_W-1:0];
            end
            if (start_wr) begin
                wdata_q <= mdr_q;
            end
            if (state_q == RD1) begin
                rdata_q <= ram[addr_q];
            end
        end
    end

    // Storage is never cleared; clr only blocks a pending write.
    always_ff @(posedge clk) begin
        if (!clr && (state_q == WR)) begin
            ram[addr_q] <= wdata_q;
        end
    end

    assign MDR_out = mdr_q;
    assign MAR_out = mar_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule
